median_window_3x3: RTL and testbench
====================================

# median_window_3x3

Streaming 3x3 neighbourhood generator that sits directly upstream of the 9-input median finder. It accepts one raster-order pixel per valid cycle and buffers the two previous image lines. For every pixel whose 3x3 neighbourhood lies fully inside the frame, it emits that neighbourhood as nine parallel 8-bit pixels in the order the median finder consumes, plus the window-centre coordinates and an end-of-frame flag.

## Interface

Parameters:
- IMG_WIDTH, 640: pixels per line; must be ≥ 3.
- IMG_HEIGHT, 480: lines per frame; must be ≥ 3.
- COL_W, $clog2(IMG_WIDTH): column counter / coordinate width.
- ROW_W, $clog2(IMG_HEIGHT): row counter / coordinate width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_pixel/in_sof are accepted this cycle; always accepted, no backpressure.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_pixel  in  8  input pixel, raster order.
- win_valid  out  1  pixel0..pixel8, win_row, win_col and frame_done are valid this cycle.
- pixel0, pixel1, pixel2  out  8 each  top window row (r-2), left to right.
- pixel3, pixel4, pixel5  out  8 each  middle row (r-1), left to right; pixel4 is the centre.
- pixel6, pixel7, pixel8  out  8 each  bottom row (r), left to right.
- win_row  out  ROW_W  centre row of the window (r-1).
- win_col  out  COL_W  centre column of the window (c-1).
- frame_done  out  1  high together with win_valid on the last window of a frame.

## Operation

- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the coordinate (r, c) of the pixel accepted this cycle.
  - Both advance only on in_valid.
  - col wraps to 0 after IMG_WIDTH-1 and increments row.
  - row wraps to 0 after IMG_HEIGHT-1.
- in_sof with in_valid forces the accepted pixel to (0,0); the counters then continue from (0,1).
  - An in_sof mid-frame abandons the partial frame, with no frame_done for it.
  - in_sof without in_valid is ignored.
- Two line buffers, each IMG_WIDTH × 8 (register array or inferred RAM), both indexed by c:
  - lb0[c] holds row r-1; lb1[c] holds row r-2.
  - On each accepted pixel, read lb1[c] and lb0[c], then write lb1[c] ← lb0[c] and lb0[c] ← in_pixel.
- Window register: 3 columns × 3 rows.
  - On each accepted pixel, the window shifts left by one column.
  - The new right column is {lb1[c], lb0[c], in_pixel} for rows r-2, r-1 and r.
- A window is emitted when the accepted pixel has r ≥ 2 and c ≥ 2.
  - Centre is (r-1, c-1); there are (IMG_WIDTH-2)(IMG_HEIGHT-2) windows per frame.
  - No windows are produced for border centres; border policy belongs downstream.
- frame_done = 1 on the window emitted for (IMG_HEIGHT-1, IMG_WIDTH-1).
- Stale window columns left over from the previous line (c = 0, 1) are never emitted.
- Line buffer contents are not reset. Nothing is emitted until two full lines have been written after reset or in_sof.

## Timing

- Latency: 1 cycle. The pixel accepted in cycle N, if it qualifies, produces win_valid = 1 and the outputs in cycle N+1.
- win_valid is a single-cycle pulse per qualifying pixel. Back-to-back in_valid gives back-to-back windows.
- Outputs hold their last value while win_valid = 0. Consumers qualify data with win_valid only.
- in_valid gaps of any length freeze all state.
- Reset (rst_n = 0 at a rising edge) sets:
  - col = 0, row = 0;
  - win_valid = 0, frame_done = 0;
  - pixel0..pixel8 = 0, win_row = 0, win_col = 0;
  - window register = 0.
- Reset mid-frame: the next accepted pixel is (0,0), regardless of in_sof.
- Reset has priority over in_valid in the same cycle; that pixel is dropped.
- Row and column wrap in the same cycle (last pixel of a frame): the window for that pixel is still emitted with frame_done = 1, and the next pixel is (0,0).

## Test plan

For the first three scenarios: IMG_WIDTH = 5, IMG_HEIGHT = 4, pixel(r,c) = 16r + c, in_valid held high, in_sof with the first pixel.

- **First window:** the pixel at (2,2) is accepted → next cycle win_valid = 1, pixel0..pixel8 = 0x00,01,02,10,11,12,20,21,22, win_row = 1, win_col = 1, frame_done = 0.
- **Full frame:** exactly 6 win_valid pulses, with centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
  - The last pulse has pixel8 = 0x34, pixel0 = 0x12 and frame_done = 1.
  - No pulse occurs for c < 2 or r < 2.
- **Back-to-back frames:** a second frame (values + 0x80) follows with no gap → its first window has pixel0 = 0x80 and pixel8 = 0xA2, with no stale data from frame 1.
- **Bubbles:** in_valid randomly deasserted 50% of cycles → the same 6 windows with identical data.
  - win_valid never asserts in a cycle that does not follow an accepted qualifying pixel.
- **Reset mid-frame:** rst_n = 0 for one cycle after pixel (2,3) → outputs are all 0 and win_valid = 0. A fresh frame without in_sof yields its first window at (1,1) with pixel0 = 0x00.
- **in_sof mid-frame:** in_sof with in_valid at position (1,3) → the counters restart at (0,0). The aborted frame gets no frame_done, and the new frame emits exactly 6 windows.

Source files
------------

// File: rtl/median_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one registered window per interior pixel with a latency of one cycle.
module median_window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_pixel,
  output logic             win_valid,
  output logic [7:0]       pixel0,
  output logic [7:0]       pixel1,
  output logic [7:0]       pixel2,
  output logic [7:0]       pixel3,
  output logic [7:0]       pixel4,
  output logic [7:0]       pixel5,
  output logic [7:0]       pixel6,
  output logic [7:0]       pixel7,
  output logic [7:0]       pixel8,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d, cur_c;
  logic [ROW_W-1:0] row_q, row_d, cur_r;
  logic [7:0]       lb0 [IMG_WIDTH];
  logic [7:0]       lb1 [IMG_WIDTH];
  logic [7:0]       top_px, mid_px;

  // [row][col]: row 0 is r-2 (top), col 0 is c-2 (left)
  logic [2:0][2:0][7:0] win_q, win_d, out_q;
  logic [ROW_W-1:0]     wrow_q;
  logic [COL_W-1:0]     wcol_q;
  logic                 wvld_q, fdone_q, emit;

  always_comb begin
    cur_c  = in_sof ? '0 : col_q;
    cur_r  = in_sof ? '0 : row_q;
    top_px = lb1[cur_c];
    mid_px = lb0[cur_c];
    col_d  = col_q;
    row_d  = row_q;
    win_d  = win_q;
    emit   = 1'b0;
    if (in_valid) begin
      if (cur_c == LAST_COL) begin
        col_d = '0;
        row_d = (cur_r == LAST_ROW) ? '0 : cur_r + 1'b1;
      end else begin
        col_d = cur_c + 1'b1;
        row_d = cur_r;
      end
      for (int k = 0; k < 3; k++) begin
        win_d[k][0] = win_q[k][1];
        win_d[k][1] = win_q[k][2];
      end
      win_d[0][2] = top_px;
      win_d[1][2] = mid_px;
      win_d[2][2] = in_pixel;
      // columns c-2..c all belong to the current line once c >= 2
      emit = (cur_r >= ROW_W'(2)) && (cur_c >= COL_W'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      out_q   <= '0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      wvld_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      wvld_q  <= emit;
      fdone_q <= emit && (cur_r == LAST_ROW) && (cur_c == LAST_COL);
      if (emit) begin
        out_q  <= win_d;
        wrow_q <= cur_r - 1'b1;
        wcol_q <= cur_c - 1'b1;
      end
    end
  end

  // Line buffers are intentionally not reset; rows 0/1 overwrite them before any emit.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      lb1[cur_c] <= mid_px;
      lb0[cur_c] <= in_pixel;
    end
  end

  assign win_valid  = wvld_q;
  assign frame_done = fdone_q;
  assign win_row    = wrow_q;
  assign win_col    = wcol_q;
  assign pixel0     = out_q[0][0];
  assign pixel1     = out_q[0][1];
  assign pixel2     = out_q[0][2];
  assign pixel3     = out_q[1][0];
  assign pixel4     = out_q[1][1];
  assign pixel5     = out_q[1][2];
  assign pixel6     = out_q[2][0];
  assign pixel7     = out_q[2][1];
  assign pixel8     = out_q[2][2];

endmodule

// File: tb/tb_median_window_3x3.sv
// Scoreboarded bench for median_window_3x3 on a 5x4 frame with pixel(r,c) = 16r + c + offset.
module tb_median_window_3x3;
  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic       win_valid, frame_done;
  logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8;
  logic [1:0] win_row;
  logic [2:0] win_col;
  logic [8:0][7:0] dut_p;

  median_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .win_valid(win_valid),
    .pixel0(pixel0), .pixel1(pixel1), .pixel2(pixel2),
    .pixel3(pixel3), .pixel4(pixel4), .pixel5(pixel5),
    .pixel6(pixel6), .pixel7(pixel7), .pixel8(pixel8),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  assign dut_p = {pixel8, pixel7, pixel6, pixel5, pixel4, pixel3, pixel2, pixel1, pixel0};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][7:0] p;
    logic [1:0]      row;
    logic [2:0]      col;
    logic            fd;
  } win_t;

  typedef struct {
    int row, col, p0, p4, p8, fd;
  } tab_t;

  tab_t tab [6];
  win_t sbq [$];
  win_t got [$];
  int   checks = 0;
  int   fails  = 0;
  int   pulses = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic win_t mkwin(input int r, input int c, input int off);
    win_t w;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w.p[dr*3+dc] = 8'(16*(r-2+dr) + (c-2+dc) + off);
    w.row = 2'(r-1);
    w.col = 3'(c-1);
    w.fd  = (r == H-1) && (c == W-1);
    return w;
  endfunction

  // Drive one cycle, then check the result of that cycle's edge against the scoreboard.
  task automatic step(input logic v, input logic s, input logic [7:0] px,
                      input logic exp_emit, input win_t exp);
    win_t e, a;
    in_valid = v;
    in_sof   = s;
    in_pixel = px;
    if (exp_emit) sbq.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("win_valid", int'(win_valid), int'(exp_emit));
    if (win_valid) begin
      pulses++;
      a.p = dut_p; a.row = win_row; a.col = win_col; a.fd = frame_done;
      got.push_back(a);
      if (sbq.size() == 0) chk("spurious_window", 1, 0);
      else begin
        e = sbq.pop_front();
        for (int k = 0; k < 9; k++) chk($sformatf("pixel%0d", k), int'(dut_p[k]), int'(e.p[k]));
        chk("win_row", int'(win_row), int'(e.row));
        chk("win_col", int'(win_col), int'(e.col));
        chk("frame_done", int'(frame_done), int'(e.fd));
      end
    end else begin
      chk("frame_done_idle", int'(frame_done), 0);
    end
  endtask

  task automatic pixel_at(input int r, input int c, input int off, input logic sof);
    step(1'b1, sof, 8'(16*r + c + off), (r >= 2) && (c >= 2), mkwin(r, c, off));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, '0);
  endtask

  task automatic run_frame(input string nm, input int off, input logic sof, input int bub);
    got.delete();
    pulses = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while (bub > 0 && $urandom_range(99) < bub) idle();
        pixel_at(r, c, off, sof && r == 0 && c == 0);
      end
    chk({nm, "_pulses"}, pulses, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        chk({nm, "_row"}, int'(got[i].row), tab[i].row);
        chk({nm, "_col"}, int'(got[i].col), tab[i].col);
        chk({nm, "_p0"},  int'(got[i].p[0]), tab[i].p0 + off);
        chk({nm, "_p4"},  int'(got[i].p[4]), tab[i].p4 + off);
        chk({nm, "_p8"},  int'(got[i].p[8]), tab[i].p8 + off);
        chk({nm, "_fd"},  int'(got[i].fd), tab[i].fd);
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, int'(win_valid), 0);
    chk({nm, "_fd"}, int'(frame_done), 0);
    chk({nm, "_pix"}, (dut_p == '0) ? 0 : 1, 0);
    chk({nm, "_row"}, int'(win_row), 0);
    chk({nm, "_col"}, int'(win_col), 0);
  endtask

  initial begin
    tab[0] = '{1, 1, 'h00, 'h11, 'h22, 0};
    tab[1] = '{1, 2, 'h01, 'h12, 'h23, 0};
    tab[2] = '{1, 3, 'h02, 'h13, 'h24, 0};
    tab[3] = '{2, 1, 'h10, 'h21, 'h32, 0};
    tab[4] = '{2, 2, 'h11, 'h22, 'h33, 0};
    tab[5] = '{2, 3, 'h12, 'h23, 'h34, 1};

    rst_n = 1'b0;
    idle();
    idle();
    chk_zero("reset");
    rst_n = 1'b1;

    run_frame("frame1", 0, 1'b1, 0);
    run_frame("frame2", 'h80, 1'b1, 0);
    run_frame("bubbles", 0, 1'b1, 50);

    // reset right after pixel (2,3); the pixel offered during reset is dropped
    pixel_at(0, 0, 0, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if ((r > 0 || c > 0) && (r < 2 || c <= 3)) pixel_at(r, c, 0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 8'h55, 1'b0, '0);
    chk_zero("mid_reset");
    rst_n = 1'b1;
    run_frame("after_reset", 0, 1'b0, 0);

    // in_sof arrives where (1,3) would be; the partial frame never finishes
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++)
        if (r == 0 || c < 3) pixel_at(r, c, 'h40, r == 0 && c == 0);
    run_frame("sof_abort", 0, 1'b1, 0);

    idle();
    idle();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
